// File: rtl/cla_seg_sequencer_if.sv
// Handshake and operand/result bundle for cla_seg_sequencer.
// Optional subtract port is present only when CLA_SEQ_SUB_EN is defined.
interface cla_seg_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
`ifdef CLA_SEQ_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;
    logic             busy;

    // Producer/consumer side (drives operands, takes results)
    modport master (
`ifdef CLA_SEQ_SUB_EN
        output sub,
`endif
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, overflow, busy
    );

    // Sequencer side
    modport slave (
`ifdef CLA_SEQ_SUB_EN
        input  sub,
`endif
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, overflow, busy
    );
endinterface

// File: rtl/cla_seg_sequencer.sv
// Multi-cycle WIDTH-bit adder that steps one SEG-bit carry-lookahead slice
// across the operands, LSB segment first, registering the inter-segment carry.
// Optional feature: define CLA_SEQ_SUB_EN to add the sub port (a - b).
module cla_seg_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG   = 8
) (
    input logic               clk,
    input logic               rst,
    cla_seg_sequencer_if.slave bus
);
    localparam int unsigned N    = WIDTH / SEG;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              c_out_q, c_out_d;
    logic              ovf_q, ovf_d;
    logic [IdxW-1:0]   seg_idx_q, seg_idx_d;

    logic              accept;
    logic              last_seg;

    logic [SEG-1:0]    sl_a, sl_b, sl_g, sl_p, sl_sum;
    logic              sl_cout;
    logic              sl_cmsb;

    assign accept   = (state_q == StIdle) && bus.in_valid;
    assign last_seg = (seg_idx_q == IdxW'(N - 1));

    // Lookahead slice: each carry is a flat sum-of-products of g/p and carry-in
    always_comb begin
        logic cc, pp, c_prev;
        sl_a    = a_q[seg_idx_q*SEG +: SEG];
        sl_b    = b_q[seg_idx_q*SEG +: SEG];
        sl_g    = sl_a & sl_b;
        sl_p    = sl_a ^ sl_b;
        sl_sum  = '0;
        sl_cmsb = 1'b0;
        c_prev  = carry_q;
        cc      = 1'b0;
        pp      = 1'b0;
        for (int i = 0; i < int'(SEG); i++) begin
            sl_sum[i] = sl_p[i] ^ c_prev;
            if (i == int'(SEG) - 1) sl_cmsb = c_prev;
            cc = sl_g[i];
            pp = sl_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                cc = cc | (pp & sl_g[j]);
                pp = pp & sl_p[j];
            end
            c_prev = cc | (pp & carry_q);
        end
        sl_cout = c_prev;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.in_valid)  state_d = StRun;
            StRun:   if (last_seg)      state_d = StDone;
            StDone:  if (bus.out_ready) state_d = StIdle;
            default:                    state_d = StIdle;
        endcase
    end

    // Handshake and result outputs
    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.out_valid = (state_q == StDone);
        bus.busy      = (state_q == StRun) || (state_q == StDone);
        bus.sum       = sum_q;
        bus.c_out     = c_out_q;
        bus.overflow  = ovf_q;
    end

    // Datapath next-state: latch on accept, fold in one segment per RUN cycle
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        c_out_d   = c_out_q;
        ovf_d     = ovf_q;
        seg_idx_d = seg_idx_q;
        if (accept) begin
            a_d       = bus.a;
            b_d       = bus.b;
            carry_d   = bus.c_in;
`ifdef CLA_SEQ_SUB_EN
            // a - b = a + ~b + 1
            if (bus.sub) begin
                b_d     = ~bus.b;
                carry_d = 1'b1;
            end
`endif
            seg_idx_d = '0;
            sum_d     = '0;
        end else if (state_q == StRun) begin
            sum_d[seg_idx_q*SEG +: SEG] = sl_sum;
            carry_d   = sl_cout;
            seg_idx_d = seg_idx_q + IdxW'(1);
            if (last_seg) begin
                c_out_d = sl_cout;
                ovf_d   = sl_cmsb ^ sl_cout;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            c_out_q   <= 1'b0;
            ovf_q     <= 1'b0;
            seg_idx_q <= '0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            c_out_q   <= c_out_d;
            ovf_q     <= ovf_d;
            seg_idx_q <= seg_idx_d;
        end
    end
endmodule

// File: doc/cla_seg_sequencer.md
# cla_seg_sequencer

Multi-cycle sequencer that performs a WIDTH-bit addition by stepping one SEG-bit carry-lookahead slice across the operands, least-significant segment first, and registering the inter-segment carry. It sits between the FIR accumulation path and the adder datapath. Wide sums reuse one narrow, fast CLA slice instead of a full-width adder. Operands enter and results leave through valid/ready handshakes.

## Interface
- WIDTH, 32: operand and result width in bits; must be a multiple of SEG.
- SEG, 8: slice width in bits; N = WIDTH/SEG segments, N ≥ 2.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands (high only in IDLE).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- c_in  in  1  carry into segment 0.
- sub  in  1  subtract request; present only when CLA_SEQ_SUB_EN is defined.
- out_valid  out  1  result held and valid.
- out_ready  in  1  consumer takes the result.
- sum  out  WIDTH  result.
- c_out  out  1  carry out of the MSB.
- overflow  out  1  two's-complement overflow.
- busy  out  1  high in RUN or DONE.

## Operation
- States:
  - IDLE: in_ready = 1.
  - RUN: computes one segment per cycle.
  - DONE: out_valid = 1.
- IDLE → RUN when in_valid && in_ready at a clock edge:
  - latch a and b into the operand registers;
  - latch c_in into the carry register;
  - clear segment counter seg_idx to 0;
  - clear sum to 0.
- RUN, each cycle:
  - slice inputs are a_r[seg_idx*SEG +: SEG], b_r[seg_idx*SEG +: SEG] and the carry register;
  - the slice computes generate/propagate per bit, lookahead carries, and sum = propagate XOR carry;
  - at the clock edge, the slice sum is written into sum[seg_idx*SEG +: SEG], the carry register takes the slice carry-out, and seg_idx increments.
- RUN → DONE on the edge that writes segment N-1:
  - c_out takes the final slice carry-out;
  - overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- DONE → IDLE on the edge where out_ready = 1. sum, c_out and overflow hold their values until the next accept.
- Inputs a, b, c_in and sub are ignored outside the accept edge.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Reset values (asynchronous): state = IDLE, in_ready = 1, out_valid = 0, busy = 0, sum = 0, c_out = 0, overflow = 0, seg_idx = 0, carry register = 0.
- Latency: out_valid rises N edges after the accept edge (N = 4 at the defaults).
- Peak throughput: one operation every N+2 cycles. out_ready held high gives handshake at edge N+1 and the next accept at edge N+2.
- No accept occurs in the same cycle as the output handshake: in_ready is low in DONE.
- Output stability: while out_valid = 1 and out_ready = 0, sum, c_out and overflow stay stable indefinitely.
- Reset mid-operation, in RUN or DONE: aborts immediately; all outputs return to reset values and no partial result is ever presented.
- out_ready asserted in IDLE or RUN has no effect.

## Configuration
- Macro: CLA_SEQ_SUB_EN.
- Defined:
  - the sub port exists and is latched on accept;
  - when latched sub = 1, b_r stores ~b and the carry register is loaded with 1, ignoring c_in;
  - the result is a − b;
  - c_out = 1 means no borrow;
  - overflow follows the same signed rule as addition.
- Undefined:
  - no sub port;
  - the block only adds, a + b + c_in.

## Test plan
- Defaults. a=0x0000_0003, b=0x0000_0004, c_in=0 → out_valid after 4 cycles; sum=0x0000_0007, c_out=0, overflow=0.
- Full carry ripple. a=0xFFFF_FFFF, b=0x0000_0000, c_in=1 → sum=0x0000_0000, c_out=1, overflow=0; the carry crosses all 4 segments.
- Signed overflow. a=0x7FFF_FFFF, b=0x0000_0001, c_in=0 → sum=0x8000_0000, c_out=0, overflow=1.
- Backpressure and handshake.
  - Hold out_ready=0 for 10 cycles after out_valid → sum stays stable and in_ready stays 0.
  - Pulse out_ready → out_valid falls and in_ready=1 the next cycle.
  - A second operand set presented early is not accepted until IDLE.
- Reset mid-RUN. Assert rst 2 cycles after accept of a=0x1234_5678, b=0x1111_1111 → outputs go to reset values immediately and out_valid never rises. After release, a new op 0x1+0x1 returns 0x2.
- With CLA_SEQ_SUB_EN defined. sub=1, a=5, b=7 → sum=0xFFFF_FFFE, c_out=0, overflow=0. sub=1, a=7, b=5 → sum=0x0000_0002, c_out=1.
